// File: rtl/instr_prefetch_buf.sv
// Instruction memory with a sequential prefetch FIFO feeding decode over valid/ready.
// A redirect flushes buffered and in-flight words and restarts fetch at a new PC.
module instr_prefetch_buf #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MEM_WORDS = 256,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [XLEN-1:0]              load_data,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_instr,
  output logic [XLEN-1:0]              out_pc,
  output logic [$clog2(DEPTH):0]       out_count
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0]     OCC_LIMIT = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);

  logic [XLEN-1:0] mem [MEM_WORDS];

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tag_pc_q,   tag_pc_d;
  logic [XLEN-1:0] rdata_q,    rdata_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] fifo_pc_d    [DEPTH];
  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [XLEN-1:0] fifo_instr_d [DEPTH];

  logic [AW-1:0]   mem_idx_s;
  logic [CW:0]     occupancy_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;

  // Program storage: written by the loader, never reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Issue/return/pop decisions and next-state for fetch and FIFO.
  always_comb begin
    mem_idx_s    = fetch_pc_q[AW+1:2];
    // In-flight reads reserve a slot so the returning push can never overflow.
    occupancy_s  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue_s      = !load_en && !redirect_valid && (occupancy_s < OCC_LIMIT);
    push_s       = inflight_q && !redirect_valid;
    pop_s        = (count_q != {CW{1'b0}}) && out_ready;

    fetch_pc_d   = fetch_pc_q;
    tag_pc_d     = tag_pc_q;
    rdata_d      = rdata_q;
    inflight_d   = issue_s;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (issue_s) begin
        rdata_d    = mem[mem_idx_s];
        tag_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end

      if (push_s) begin
        fifo_pc_d[wr_ptr_q]    = tag_pc_q;
        fifo_instr_d[wr_ptr_q] = rdata_q;
        wr_ptr_d               = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset also kills any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= {XLEN{1'b0}};
      rdata_q    <= {XLEN{1'b0}};
      inflight_q <= 1'b0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_pc_q[i]    <= {XLEN{1'b0}};
        fifo_instr_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      tag_pc_q     <= tag_pc_d;
      rdata_q      <= rdata_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

  // Head entry comes straight from storage registers; zeroed while empty.
  always_comb begin
    out_valid = (count_q != {CW{1'b0}});
    out_count = count_q;
    if (out_valid) begin
      out_instr = fifo_instr_q[rd_ptr_q];
      out_pc    = fifo_pc_q[rd_ptr_q];
    end else begin
      out_instr = {XLEN{1'b0}};
      out_pc    = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Directed bench for instr_prefetch_buf: scoreboard of expected {pc,instr} pairs,
// plus a small-memory instance for index wrap.
module tb_instr_prefetch_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_count;

  logic        l8_en;
  logic [2:0]  l8_addr;
  logic [31:0] l8_data;
  logic        r8_valid;
  logic [31:0] r8_pc;
  logic        o8_valid;
  logic        o8_ready;
  logic [31:0] o8_instr;
  logic [31:0] o8_pc;
  logic [2:0]  o8_count;

  logic [63:0] scb[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_extra = 0;
  logic [31:0] prog [5];

  always #5 clk = ~clk;

  instr_prefetch_buf dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_count(out_count)
  );

  instr_prefetch_buf #(.MEM_WORDS(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .load_en(l8_en), .load_addr(l8_addr), .load_data(l8_data),
    .redirect_valid(r8_valid), .redirect_pc(r8_pc),
    .out_valid(o8_valid), .out_ready(o8_ready),
    .out_instr(o8_instr), .out_pc(o8_pc), .out_count(o8_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the head against the scoreboard when a handshake will happen, then advance.
  task automatic tick();
    logic [63:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (scb.size() == 0) begin
        n_extra++;
      end else begin
        e = scb.pop_front();
        check("head_pc", 64'(out_pc), 64'(e[63:32]));
        check("head_instr", 64'(out_instr), 64'(e[31:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while (scb.size() != 0 && b < 40) begin
      tick();
      b++;
    end
    check(tag, 64'(scb.size()), 64'd0);
    scb.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    prog[0] = 32'h0020_0113; prog[1] = 32'h0030_0193; prog[2] = 32'h0031_0233;
    prog[3] = 32'h4021_8233; prog[4] = 32'h0000_1697;
    rst_n = 1'b0; load_en = 1'b0; load_addr = 8'd0; load_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    l8_en = 1'b0; l8_addr = 3'd0; l8_data = 32'd0;
    r8_valid = 1'b0; r8_pc = 32'd0; o8_ready = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst8_valid", 64'(o8_valid), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    load_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_addr = 8'(i);
      load_data = prog[i];
      tick();
    end
    load_en = 1'b0;

    // Sequential stream, 2-cycle latency, no bubbles.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) scb.push_back({32'(i * 4), prog[i]});
    do_redirect(32'h0);
    check("t1_valid_e0", 64'(out_valid), 64'd0);
    tick();
    check("t1_valid_e1", 64'(out_valid), 64'd0);
    tick();
    check("t1_valid_e2", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("t1_nobubble", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b0;
    check("t1_done", 64'(scb.size()), 64'd0);
    scb.delete();

    // Backpressure: saturate at DEPTH, then release in order.
    do_redirect(32'h0);
    repeat (6) tick();
    check("t2_full", 64'(out_count), 64'd4);
    repeat (3) tick();
    check("t2_full_hold", 64'(out_count), 64'd4);
    for (int i = 0; i < 5; i++) scb.push_back({32'(i * 4), prog[i]});
    out_ready = 1'b1;
    drain("t2_drain");
    out_ready = 1'b0;

    // Redirect with count=3 and a read in flight.
    do_redirect(32'h0);
    repeat (4) tick();
    check("t3_count3", 64'(out_count), 64'd3);
    do_redirect(32'h0000_000C);
    check("t3_flush_valid", 64'(out_valid), 64'd0);
    check("t3_flush_count", 64'(out_count), 64'd0);
    scb.push_back({32'h0000_000C, prog[3]});
    scb.push_back({32'h0000_0010, prog[4]});
    out_ready = 1'b1;
    tick();
    check("t3_valid_e1", 64'(out_valid), 64'd0);
    tick();
    check("t3_valid_e2", 64'(out_valid), 64'd1);
    drain("t3_drain");
    out_ready = 1'b0;

    // Low PC bits ignored.
    do_redirect(32'h0000_0007);
    scb.push_back({32'h0000_0004, prog[1]});
    out_ready = 1'b1;
    drain("t4_drain");
    out_ready = 1'b0;

    // Asynchronous reset mid-stream.
    do_redirect(32'h0);
    repeat (3) tick();
    check("t5_count2", 64'(out_count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(out_valid), 64'd0);
    check("t5_async_count", 64'(out_count), 64'd0);
    check("t5_async_pc", 64'(out_pc), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    scb.push_back({32'h0000_0000, prog[0]});
    out_ready = 1'b1;
    drain("t5_drain");
    out_ready = 1'b0;

    // Index wrap on the 8-word instance.
    l8_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      l8_addr = 3'(i);
      l8_data = 32'hA000_0000 | 32'(i);
      tick();
    end
    l8_en = 1'b0;
    r8_valid = 1'b1;
    r8_pc = 32'h0000_001C;
    tick();
    r8_valid = 1'b0;
    o8_ready = 1'b1;
    tick();
    tick();
    check("t6_valid", 64'(o8_valid), 64'd1);
    check("t6_pc_1c", 64'(o8_pc), 64'h1C);
    check("t6_instr_1c", 64'(o8_instr), 64'hA000_0007);
    tick();
    check("t6_pc_20", 64'(o8_pc), 64'h20);
    check("t6_instr_wrap", 64'(o8_instr), 64'hA000_0000);
    o8_ready = 1'b0;

    check("extra_outputs", 64'(n_extra), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
